mem_port_arbiter: RTL and testbench

- Shares the single byte_addressable memory port between two requesters: port 0 is the processor core (fetch and load/store), port 1 is the loader/debug DMA.
- Accepts one transaction at a time over a valid/ready handshake and grants round-robin when both ports request.
- Sequences the memory's fixed read latency and its write-completion (done) handshake.
- Returns a one-cycle response with read data or an error flag.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one byte-addressable memory port: round-robin grant,
// fixed read latency, write done/timeout sequencing and a one-cycle response.
module mem_port_arbiter #(
   parameter int WORD_SIZE     = 32,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   input  logic [WORD_SIZE-1:0] req0_addr,
   input  logic [1:0]           req0_write,
   input  logic [WORD_SIZE-1:0] req0_wdata,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [WORD_SIZE-1:0] req1_addr,
   input  logic [1:0]           req1_write,
   input  logic [WORD_SIZE-1:0] req1_wdata,
   output logic                 req1_ready,
   output logic                 resp0_valid,
   output logic                 resp1_valid,
   output logic [WORD_SIZE-1:0] resp_rdata,
   output logic                 resp_error,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [1:0]           mem_write,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   input  logic                 mem_done,
   input  logic                 mem_error,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ_WAIT  = 2'd1,
      WRITE_WAIT = 2'd2,
      RESPOND    = 2'd3
   } state_t;

   localparam logic [7:0] READ_LAST  = 8'(READ_LATENCY - 1);
   localparam logic [7:0] WRITE_LAST = 8'(WRITE_TIMEOUT - 1);

   state_t               state_r;
   logic                 last_grant_r;
   logic                 owner_r;
   logic                 err_latch_r;
   logic [7:0]           cnt_r;
   logic                 idle_s;
   logic                 accept_s;
   logic                 sel1_s;
   logic [WORD_SIZE-1:0] sel_addr_s;
   logic [WORD_SIZE-1:0] sel_wdata_s;
   logic [1:0]           sel_write_s;
   logic                 read_err_s;
   logic                 write_err_s;

   // Grant decision, accepted payload select and next error-latch values.
   always_comb begin
      idle_s      = (state_r == IDLE);
      req0_ready  = idle_s && req0_valid && (!req1_valid || last_grant_r);
      req1_ready  = idle_s && req1_valid && (!req0_valid || !last_grant_r);
      accept_s    = (req0_ready && req0_valid) || (req1_ready && req1_valid);
      sel1_s      = req1_ready;
      sel_addr_s  = sel1_s ? req1_addr  : req0_addr;
      sel_wdata_s = sel1_s ? req1_wdata : req0_wdata;
      sel_write_s = sel1_s ? req1_write : req0_write;
      read_err_s  = err_latch_r || mem_error;
      // A done on the final timeout edge wins, so the timeout contributes no error.
      write_err_s = err_latch_r || mem_error || (!mem_done && (cnt_r == WRITE_LAST));
   end

   // Transaction sequencer; all memory-side and response outputs are registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         owner_r      <= 1'b0;
         err_latch_r  <= 1'b0;
         cnt_r        <= 8'd0;
         mem_addr     <= {WORD_SIZE{1'b0}};
         mem_write    <= 2'b00;
         mem_wdata    <= {WORD_SIZE{1'b0}};
         resp_rdata   <= {WORD_SIZE{1'b0}};
         resp_error   <= 1'b0;
         resp0_valid  <= 1'b0;
         resp1_valid  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  mem_addr     <= sel_addr_s;
                  mem_write    <= sel_write_s;
                  mem_wdata    <= sel_wdata_s;
                  owner_r      <= sel1_s;
                  last_grant_r <= sel1_s;
                  err_latch_r  <= 1'b0;
                  cnt_r        <= 8'd0;
                  busy         <= 1'b1;
                  state_r      <= (sel_write_s == 2'b00) ? READ_WAIT : WRITE_WAIT;
               end
            end
            READ_WAIT: begin
               err_latch_r <= read_err_s;
               if (cnt_r == READ_LAST) begin
                  resp_rdata  <= read_err_s ? {WORD_SIZE{1'b0}} : mem_rdata;
                  resp_error  <= read_err_s;
                  resp0_valid <= !owner_r;
                  resp1_valid <= owner_r;
                  state_r     <= RESPOND;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            WRITE_WAIT: begin
               err_latch_r <= write_err_s;
               if (mem_done || (cnt_r == WRITE_LAST)) begin
                  mem_write   <= 2'b00;
                  resp_rdata  <= {WORD_SIZE{1'b0}};
                  resp_error  <= write_err_s;
                  resp0_valid <= !owner_r;
                  resp1_valid <= owner_r;
                  state_r     <= RESPOND;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            RESPOND: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               mem_write <= 2'b00;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level timing/arbitration model.
module tb_mem_port_arbiter;

   localparam int W  = 32;
   localparam int RL = 2;
   localparam int WT = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [W-1:0]  req0_addr = '0, req1_addr = '0, req0_wdata = '0, req1_wdata = '0;
   logic [1:0]    req0_write = 2'b00, req1_write = 2'b00;
   logic          req0_ready, req1_ready, resp0_valid, resp1_valid, resp_error, busy;
   logic [W-1:0]  resp_rdata, mem_addr, mem_wdata;
   logic [1:0]    mem_write;
   logic [W-1:0]  mem_rdata = '0;
   logic          mem_done = 1'b0, mem_error = 1'b0;

   int chk  = 0;
   int errs = 0;
   bit model_last = 1'b1;

   mem_port_arbiter #(.WORD_SIZE(W), .READ_LATENCY(RL), .WRITE_TIMEOUT(WT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_write(req0_write),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_write(req1_write),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
      .resp_rdata(resp_rdata), .resp_error(resp_error),
      .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_error(mem_error),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      mem_done = 1'b0; mem_error = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      model_last = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      @(negedge clk);
      chk++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      chk++; if (mem_write !== 2'b00) begin errs++; $display("FAIL reset_mem_write: got %b want 00", mem_write); end
      chk++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
      chk++; if (resp_rdata !== 32'h0) begin errs++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
      chk++; if (resp_error !== 1'b0) begin errs++; $display("FAIL reset_resp_error: got %b want 0", resp_error); end
      chk++; if ({resp0_valid, resp1_valid} !== 2'b00) begin errs++; $display("FAIL reset_resp_valid: got %b want 00", {resp0_valid, resp1_valid}); end
      chk++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
      tick();
      rst = 1'b1;
      model_last = 1'b1;
      @(negedge clk);
      chk++; if ({req0_ready, req1_ready} !== 2'b00) begin errs++; $display("FAIL reset_ready_idle: got %b want 00", {req0_ready, req1_ready}); end
      tick();
   endtask

   task automatic test_port0_read();
      req0_valid = 1'b1; req0_addr = 32'h10; req0_write = 2'b00; req0_wdata = 32'h0;
      mem_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      chk++; if ({req0_ready, req1_ready} !== 2'b10) begin errs++; $display("FAIL p0read_ready: got %b want 10", {req0_ready, req1_ready}); end
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      chk++; if (mem_addr !== 32'h10) begin errs++; $display("FAIL p0read_addr: got %h want 10", mem_addr); end
      chk++; if (busy !== 1'b1) begin errs++; $display("FAIL p0read_busy: got %b want 1", busy); end
      chk++; if (resp0_valid !== 1'b0) begin errs++; $display("FAIL p0read_early1: got %b want 0", resp0_valid); end
      tick();
      mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk++; if (resp0_valid !== 1'b0) begin errs++; $display("FAIL p0read_early2: got %b want 0", resp0_valid); end
      tick();
      mem_rdata = 32'h0;
      @(negedge clk);
      chk++; if ({resp0_valid, resp1_valid} !== 2'b10) begin errs++; $display("FAIL p0read_resp: got %b want 10", {resp0_valid, resp1_valid}); end
      chk++; if (resp_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL p0read_rdata: got %h want deadbeef", resp_rdata); end
      chk++; if (resp_error !== 1'b0) begin errs++; $display("FAIL p0read_error: got %b want 0", resp_error); end
      tick();
      @(negedge clk);
      chk++; if ({resp0_valid, busy} !== 2'b00) begin errs++; $display("FAIL p0read_after: got %b want 00", {resp0_valid, busy}); end
      tick();
   endtask

   task automatic test_tie_alternation();
      do_reset();
      req0_valid = 1'b1; req0_addr = 32'h100; req0_write = 2'b00;
      req1_valid = 1'b1; req1_addr = 32'h200; req1_write = 2'b00;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         chk++; if (busy !== 1'b0) begin errs++; $display("FAIL tie_idle_busy t%0d: got %b want 0", t, busy); end
         chk++; if ({req0_ready, req1_ready} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL tie_grant t%0d: got %b", t, {req0_ready, req1_ready}); end
         tick();
         for (int c = 1; c <= RL + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
               chk++; if (mem_addr !== ((t % 2 == 0) ? 32'h100 : 32'h200)) begin errs++; $display("FAIL tie_addr t%0d: got %h", t, mem_addr); end
            end
            if (c <= RL) begin
               chk++; if ({resp0_valid, resp1_valid} !== 2'b00) begin errs++; $display("FAIL tie_early t%0d: got %b want 00", t, {resp0_valid, resp1_valid}); end
            end else begin
               chk++; if ({resp0_valid, resp1_valid} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL tie_resp t%0d: got %b", t, {resp0_valid, resp1_valid}); end
            end
            tick();
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_port1_write();
      req1_valid = 1'b1; req1_addr = 32'h20; req1_write = 2'b11; req1_wdata = 32'h1234_5678;
      @(negedge clk);
      chk++; if (req1_ready !== 1'b1) begin errs++; $display("FAIL p1write_ready: got %b want 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         mem_done = (c == 4);
         @(negedge clk);
         if (c < 5) begin
            chk++; if (mem_write !== 2'b11) begin errs++; $display("FAIL p1write_wr c%0d: got %b want 11", c, mem_write); end
            chk++; if (resp1_valid !== 1'b0) begin errs++; $display("FAIL p1write_early c%0d: got %b want 0", c, resp1_valid); end
         end else begin
            chk++; if ({resp0_valid, resp1_valid} !== 2'b01) begin errs++; $display("FAIL p1write_resp: got %b want 01", {resp0_valid, resp1_valid}); end
            chk++; if (resp_error !== 1'b0) begin errs++; $display("FAIL p1write_error: got %b want 0", resp_error); end
            chk++; if (mem_write !== 2'b00) begin errs++; $display("FAIL p1write_wr_after: got %b want 00", mem_write); end
         end
         if (c == 1) begin
            chk++; if ({mem_addr, mem_wdata} !== {32'h20, 32'h1234_5678}) begin errs++; $display("FAIL p1write_payload: got %h %h", mem_addr, mem_wdata); end
         end
         tick();
      end
      mem_done = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      req0_valid = 1'b1; req0_addr = 32'h44; req0_write = 2'b01; req0_wdata = 32'h0000_00A5;
      mem_done = 1'b0;
      tick();
      req0_valid = 1'b0;
      for (int c = 1; c <= WT + 1; c++) begin
         @(negedge clk);
         if (c <= WT) begin
            chk++; if ({resp0_valid, mem_write} !== 3'b001) begin errs++; $display("FAIL timeout_wait c%0d: got valid=%b wr=%b want 0/01", c, resp0_valid, mem_write); end
         end else begin
            chk++; if (resp0_valid !== 1'b1) begin errs++; $display("FAIL timeout_resp: got %b want 1", resp0_valid); end
            chk++; if (resp_error !== 1'b1) begin errs++; $display("FAIL timeout_error: got %b want 1", resp_error); end
            chk++; if (mem_write !== 2'b00) begin errs++; $display("FAIL timeout_wr: got %b want 00", mem_write); end
         end
         tick();
      end
      tick();
   endtask

   task automatic test_misaligned_read();
      req1_valid = 1'b1; req1_addr = 32'h31; req1_write = 2'b00;
      mem_rdata = 32'hCAFE_F00D;
      tick();
      req1_valid = 1'b0;
      mem_error = 1'b1;
      tick();
      mem_error = 1'b0;
      @(negedge clk);
      chk++; if (resp1_valid !== 1'b0) begin errs++; $display("FAIL misaligned_early: got %b want 0", resp1_valid); end
      tick();
      @(negedge clk);
      chk++; if (resp1_valid !== 1'b1) begin errs++; $display("FAIL misaligned_resp: got %b want 1", resp1_valid); end
      chk++; if (resp_error !== 1'b1) begin errs++; $display("FAIL misaligned_error: got %b want 1", resp_error); end
      chk++; if (resp_rdata !== 32'h0) begin errs++; $display("FAIL misaligned_rdata: got %h want 0", resp_rdata); end
      tick();
      tick();
   endtask

   task automatic test_reset_mid_write();
      req1_valid = 1'b1; req1_addr = 32'h40; req1_write = 2'b10; req1_wdata = 32'hA5A5_5A5A;
      mem_done = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk++; if (mem_write !== 2'b10) begin errs++; $display("FAIL rstmid_wr_before: got %b want 10", mem_write); end
      tick();
      rst = 1'b0;
      #1;
      chk++; if (mem_write !== 2'b00) begin errs++; $display("FAIL rstmid_wr_async: got %b want 00", mem_write); end
      chk++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk++; if ({resp0_valid, resp1_valid} !== 2'b00) begin errs++; $display("FAIL rstmid_noresp c%0d: got %b want 00", c, {resp0_valid, resp1_valid}); end
         tick();
      end
      rst = 1'b1;
      model_last = 1'b1;
      @(negedge clk);
      chk++; if (req1_ready !== 1'b1) begin errs++; $display("FAIL rstmid_reaccept: got %b want 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      mem_done = 1'b1;
      @(negedge clk);
      chk++; if ({busy, mem_write} !== 3'b110) begin errs++; $display("FAIL rstmid_rewrite: got busy=%b wr=%b want 1/10", busy, mem_write); end
      tick();
      mem_done = 1'b0;
      @(negedge clk);
      chk++; if ({resp1_valid, resp_error} !== 2'b10) begin errs++; $display("FAIL rstmid_resp: got %b want 10", {resp1_valid, resp_error}); end
      tick();
      tick();
   endtask

   task automatic test_random();
      logic        pend  [2];
      logic [31:0] paddr [2];
      logic [31:0] pdata [2];
      logic [1:0]  pwr   [2];
      logic [31:0] rd_val, exp_rdata;
      int          g, resp_cyc, done_at, err_cyc;
      bit          is_wr, err_pulse, timed_out, exp_err;
      do_reset();
      pend[0] = 1'b0; pend[1] = 1'b0;
      for (int it = 0; it < 60; it++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && (($urandom_range(0, 2) != 0) || (p == 1 && !pend[0]))) begin
               pend[p]  = 1'b1;
               paddr[p] = $urandom;
               pdata[p] = $urandom;
               pwr[p]   = 2'($urandom_range(0, 3));
            end
         end
         req0_valid = pend[0]; req0_addr = paddr[0]; req0_wdata = pdata[0]; req0_write = pwr[0];
         req1_valid = pend[1]; req1_addr = paddr[1]; req1_wdata = pdata[1]; req1_write = pwr[1];
         g         = (pend[0] && pend[1]) ? (model_last ? 0 : 1) : (pend[0] ? 0 : 1);
         is_wr     = (pwr[g] != 2'b00);
         done_at   = $urandom_range(1, WT + 3);
         timed_out = is_wr && (done_at > WT);
         resp_cyc  = !is_wr ? RL + 1 : (timed_out ? WT + 1 : done_at + 1);
         err_pulse = ($urandom_range(0, 3) == 0);
         err_cyc   = $urandom_range(1, resp_cyc - 1);
         exp_err   = err_pulse || timed_out;
         rd_val    = $urandom;
         exp_rdata = (is_wr || exp_err) ? 32'h0 : rd_val;
         mem_done = 1'b0; mem_error = 1'b0; mem_rdata = ~rd_val;
         @(negedge clk);
         chk++; if (busy !== 1'b0) begin errs++; $display("FAIL rnd_idle_busy it%0d: got %b want 0", it, busy); end
         chk++; if ({req0_ready, req1_ready} !== ((g == 0) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL rnd_grant it%0d: got %b want port %0d", it, {req0_ready, req1_ready}, g); end
         tick();
         if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
         pend[g]    = 1'b0;
         model_last = (g == 1);
         for (int c = 1; c <= resp_cyc; c++) begin
            mem_done  = is_wr && !timed_out && (c == done_at);
            mem_error = err_pulse && (c == err_cyc);
            mem_rdata = (c >= RL) ? rd_val : ~rd_val;
            @(negedge clk);
            if (c == 1) begin
               chk++; if (mem_addr !== paddr[g]) begin errs++; $display("FAIL rnd_addr it%0d: got %h want %h", it, mem_addr, paddr[g]); end
               if (is_wr) begin
                  chk++; if (mem_wdata !== pdata[g]) begin errs++; $display("FAIL rnd_wdata it%0d: got %h want %h", it, mem_wdata, pdata[g]); end
               end
            end
            if (c < resp_cyc) begin
               chk++; if ({resp0_valid, resp1_valid, req0_ready, req1_ready} !== 4'b0000) begin errs++; $display("FAIL rnd_wait it%0d c%0d: got valid/ready %b want 0000", it, c, {resp0_valid, resp1_valid, req0_ready, req1_ready}); end
               chk++; if (mem_write !== (is_wr ? pwr[g] : 2'b00)) begin errs++; $display("FAIL rnd_wr it%0d c%0d: got %b want %b", it, c, mem_write, is_wr ? pwr[g] : 2'b00); end
            end else begin
               chk++; if ({resp0_valid, resp1_valid} !== ((g == 0) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL rnd_resp it%0d: got %b want port %0d", it, {resp0_valid, resp1_valid}, g); end
               chk++; if (resp_error !== exp_err) begin errs++; $display("FAIL rnd_error it%0d: got %b want %b", it, resp_error, exp_err); end
               chk++; if (resp_rdata !== exp_rdata) begin errs++; $display("FAIL rnd_rdata it%0d: got %h want %h", it, resp_rdata, exp_rdata); end
               chk++; if (mem_write !== 2'b00) begin errs++; $display("FAIL rnd_wr_end it%0d: got %b want 00", it, mem_write); end
            end
            tick();
         end
         mem_done = 1'b0; mem_error = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chk++; if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin errs++; $display("FAIL rnd_final_idle: got %b want 000", {resp0_valid, resp1_valid, busy}); end
      tick();
   endtask

   initial begin
      test_reset();
      test_port0_read();
      test_tie_alternation();
      test_port1_write();
      test_timeout();
      test_misaligned_read();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", chk, errs);
      $finish;
   end

endmodule
